// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: shares one write port between the ALU and
// load-return paths, with a per-register load scoreboard driving decode hazards.
module rf_wb_arbiter #(
    parameter int XLEN       = 64,
    parameter int NREG       = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_rd,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hazard,
    output logic [NREG-1:0] busy,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_MEM} gnt_e;

    localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

    logic [NREG-1:0] busy_q, busy_d;
    logic [1:0]      starve_q, starve_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    gnt_e            gnt;
    logic            alu_req, mem_req;
    logic [AW-1:0]   win_rd;
    logic [XLEN-1:0] win_data;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        gnt      = GNT_NONE;
        alu_req  = alu_valid && !((alu_rd != '0) && busy_q[alu_rd]);
        mem_req  = mem_valid;
        win_rd   = '0;
        win_data = '0;

        if (!reset) begin
            if (mem_req && (!alu_req || (starve_q < STARVE_LIM)))
                gnt = GNT_MEM;
            else if (alu_req)
                gnt = GNT_ALU;
        end

        if (gnt == GNT_MEM) begin
            win_rd   = mem_rd;
            win_data = mem_data;
        end else if (gnt == GNT_ALU) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end

        starve_d = starve_q;
        if (gnt == GNT_ALU || !alu_req)
            starve_d = '0;
        else if (gnt == GNT_MEM && starve_q != 2'b11)
            starve_d = starve_q + 2'd1;

        // x0 grants complete the handshake but never reach the register file.
        rf_we_d    = (gnt != GNT_NONE) && (win_rd != '0);
        rf_rd_d    = (gnt != GNT_NONE) ? win_rd   : rf_rd_q;
        rf_wdata_d = (gnt != GNT_NONE) ? win_data : rf_wdata_q;

        // NOTE: set is applied after clear so a new load to the retiring register stays outstanding.
        busy_d = busy_q;
        if (gnt == GNT_MEM && mem_rd != '0)
            busy_d[mem_rd] = 1'b0;
        if (ld_issue && ld_rd != '0)
            busy_d[ld_rd] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments; reset here is synchronous to clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q     <= busy_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign alu_ready = (gnt == GNT_ALU);
    assign mem_ready = (gnt == GNT_MEM);
    assign hazard    = !reset && (((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]));
    assign busy      = busy_q;
    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: stimulus pushes expected register-file writes
// into a queue that a separate monitor drains against rf_we/rf_rd/rf_wdata.
module tb_rf_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid, ld_issue, mem_valid;
    logic [AW-1:0]   alu_rd, ld_rd, mem_rd, rs1, rs2;
    logic [XLEN-1:0] alu_data, mem_data;
    logic            alu_ready, mem_ready, hazard, rf_we;
    logic [NREG-1:0] busy;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;
    wr_t exp_q[$];

    rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .STARVE_MAX(2)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_issue(ld_issue), .ld_rd(ld_rd),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rs1(rs1), .rs2(rs2), .hazard(hazard), .busy(busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_wr(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
        exp_q.push_back({rd, data});
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        ld_issue  = 1'b0;
        rs1       = '0;
        rs2       = '0;
    endtask

    // Monitor: each cycle either exactly one expected write retires or rf_we stays low.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    check("rf_we_idle", 64'(rf_we), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rf_we", 64'(rf_we), 64'd1);
                    if (rf_we === 1'b1) begin
                        check("rf_rd", 64'(rf_rd), 64'(e.rd));
                        check("rf_wdata", rf_wdata, e.data);
                    end
                end
            end
        end
    end

    initial begin
        bit [3:0] mem_pat = 4'b1011;

        reset = 1'b1;
        idle();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
        ld_rd = '0;

        // Reset held with both requesters active.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("rst_alu_ready", 64'(alu_ready), 64'd0);
            check("rst_mem_ready", 64'(mem_ready), 64'd0);
            check("rst_rf_we", 64'(rf_we), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_hazard", 64'(hazard), 64'd0);
        end

        // First cycle after release: both requesting, starve count 0 -> mem wins.
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        #1;
        check("post_rst_mem_ready", 64'(mem_ready), 64'd1);
        check("post_rst_alu_ready", 64'(alu_ready), 64'd0);
        if (mem_ready === 1'b1) expect_wr(5'd2, 64'h22);

        @(negedge clk); idle();

        // ALU only.
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        #1;
        check("alu_only_ready", 64'(alu_ready), 64'd1);
        check("alu_only_mem_ready", 64'(mem_ready), 64'd0);
        if (alu_ready === 1'b1) expect_wr(5'd5, 64'h1234);
        @(negedge clk); idle();
        @(negedge clk);

        // Contention: mem, mem, alu, mem.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hA3;
            mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 64'hD0 + 64'(i);
            #1;
            check($sformatf("cont%0d_mem_ready", i), 64'(mem_ready), 64'(mem_pat[i]));
            check($sformatf("cont%0d_alu_ready", i), 64'(alu_ready), 64'(!mem_pat[i]));
            if (mem_pat[i]) expect_wr(5'd4, 64'hD0 + 64'(i));
            else            expect_wr(5'd3, 64'hA3);
        end
        @(negedge clk); idle();

        // Scoreboard set and hazard latency (no same-cycle bypass).
        @(negedge clk);
        ld_issue = 1'b1; ld_rd = 5'd7; rs1 = 5'd7;
        #1;
        check("sb_no_bypass", 64'(hazard), 64'd0);
        @(negedge clk);
        ld_issue = 1'b0; rs1 = 5'd7;
        #1;
        check("sb_hazard_rs1", 64'(hazard), 64'd1);
        check("sb_busy7", 64'(busy), 64'h80);
        @(negedge clk);
        rs1 = 5'd0; rs2 = 5'd7;
        #1;
        check("sb_hazard_rs2", 64'(hazard), 64'd1);
        @(negedge clk);
        rs2 = 5'd0; rs1 = 5'd7;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'hAA;
        #1;
        check("sb_ret_mem_ready", 64'(mem_ready), 64'd1);
        check("sb_ret_hazard_still", 64'(hazard), 64'd1);
        if (mem_ready === 1'b1) expect_wr(5'd7, 64'hAA);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("sb_release_hazard", 64'(hazard), 64'd0);
        check("sb_release_busy", 64'(busy), 64'd0);

        // WAW guard on a pending load, then x0 writes.
        @(negedge clk);
        idle();
        ld_issue = 1'b1; ld_rd = 5'd9;
        @(negedge clk);
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        #1;
        check("waw_stall0", 64'(alu_ready), 64'd0);
        @(negedge clk); #1;
        check("waw_stall1", 64'(alu_ready), 64'd0);
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'h55;
        #1;
        check("waw_mem_ready", 64'(mem_ready), 64'd1);
        check("waw_alu_blocked", 64'(alu_ready), 64'd0);
        if (mem_ready === 1'b1) expect_wr(5'd9, 64'h55);
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        check("waw_alu_granted", 64'(alu_ready), 64'd1);
        if (alu_ready === 1'b1) expect_wr(5'd9, 64'h99);
        @(negedge clk);
        alu_rd = 5'd0; alu_data = 64'hDEAD;
        #1;
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        ld_issue = 1'b1; ld_rd = 5'd0;
        @(negedge clk);
        ld_issue = 1'b0;
        #1;
        check("x0_ld_busy", 64'(busy), 64'd0);

        // Simultaneous set and clear of one register: set wins.
        @(negedge clk);
        ld_issue = 1'b1; ld_rd = 5'd12;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'hC;
        #1;
        check("setclr_mem_ready", 64'(mem_ready), 64'd1);
        if (mem_ready === 1'b1) expect_wr(5'd12, 64'hC);
        @(negedge clk);
        idle();
        rs1 = 5'd12;
        #1;
        check("setclr_busy", 64'(busy), 64'h1000);
        check("setclr_hazard", 64'(hazard), 64'd1);

        // Re-issue to a busy register keeps it set; one return clears it.
        @(negedge clk);
        ld_issue = 1'b1; ld_rd = 5'd12;
        @(negedge clk);
        ld_issue = 1'b0;
        #1;
        check("reissue_busy", 64'(busy), 64'h1000);
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'hCC;
        #1;
        if (mem_ready === 1'b1) expect_wr(5'd12, 64'hCC);
        @(negedge clk);
        idle();
        #1;
        check("final_busy", 64'(busy), 64'd0);

        @(negedge clk);
        @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
